cbus_arbiter: RTL and testbench



---
 rtl/cbus_pkg.sv | 37 +++
 rtl/cbus_arbiter_rr_picker.sv | 41 ++++
 rtl/cbus_arbiter.sv | 97 +++++++++
 tb/tb_cbus_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_pkg.sv
// cbus_pkg
// Types and constants shared by the CBus arbiter and the logic around it.
//   cbus_req_t  : one upstream/downstream request (valid, is_write, size,
//                 addr, strobe, data, len)
//   cbus_resp_t : one response beat (ready, last, data)
//   arb_state_t : arbiter FSM states
package cbus_pkg;

    localparam int MAX_REQ = 8;

    // Transfer size encodings, AXI AxSIZE style (bytes = 2**size).
    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin selector. Scans the valid vector starting at
// the index just after last_sel (wrapping at NUM_REQ) and returns the first
// valid index found.
//   valid    : one request-valid bit per requester
//   last_sel : index granted most recently
//   sel_next : chosen index (meaningful only when any = 1)
//   any      : at least one requester is valid
module rr_picker
    import cbus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last_sel,
    output logic [IDX_W-1:0]   sel_next,
    output logic               any
);

    int cand;

    // Walk the candidates from farthest to nearest so that the nearest
    // valid one (highest priority) is the last to write sel_next.
    always_comb begin
        sel_next = '0;
        cand     = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = int'(last_sel) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (valid[cand]) begin
                sel_next = IDX_W'(cand);
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter
// Shares one downstream CBus between NUM_REQ upstream requesters. A request
// is granted with round-robin priority, the grant is held until the
// downstream signals ready && last, and responses are routed only to the
// granted requester.
//   clk, resetn : clock and asynchronous active-low reset
//   ireqs       : upstream requests, one per requester
//   iresps      : upstream responses, all-zero except for the granted one
//   oreq        : downstream request (all-zero while idle)
//   oresp       : downstream response
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  ireqs  [NUM_REQ],
    output cbus_resp_t iresps [NUM_REQ],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   last_sel;
    logic [NUM_REQ-1:0] valid_vec;
    logic [IDX_W-1:0]   sel_next;
    logic               any_valid;

    always_comb begin
        valid_vec = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            valid_vec[j] = ireqs[j].valid;
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .valid    (valid_vec),
        .last_sel (last_sel),
        .sel_next (sel_next),
        .any      (any_valid)
    );

    // last_sel resets to the highest index so requester 0 wins the first
    // arbitration. Returning to IDLE after the last beat, rather than
    // re-arbitrating in the same cycle, gives the mandatory idle cycle
    // between transactions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            sel      <= '0;
            last_sel <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        sel      <= sel_next;
                        last_sel <= sel_next;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (oresp.ready && oresp.last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request and response paths are pure muxes gated by the state, so an
    // asynchronous reset clears them immediately and a response arriving
    // while idle is never routed anywhere.
    always_comb begin
        oreq = '0;
        if (state == BUSY) begin
            oreq = ireqs[sel];
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            iresps[j] = '0;
            if (state == BUSY && sel == IDX_W'(j)) begin
                iresps[j] = oresp;
            end
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter
// Directed, self-checking bench for cbus_arbiter with two requesters.
// Inputs are driven just after the falling edge; outputs are checked 1 ns
// later, well away from the rising (active) edge.
module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int N = 2;

    logic       clk;
    logic       resetn;
    cbus_req_t  ireqs  [N];
    cbus_resp_t iresps [N];
    cbus_req_t  oreq;
    cbus_resp_t oresp;

    int checks;
    int passes;

    cbus_arbiter #(.NUM_REQ(N)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic set_req(input int idx, input logic v, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] l, input logic [3:0] s);
        ireqs[idx].valid    = v;
        ireqs[idx].is_write = w;
        ireqs[idx].size     = SIZE_WORD;
        ireqs[idx].addr     = a;
        ireqs[idx].data     = d;
        ireqs[idx].len      = l;
        ireqs[idx].strobe   = s;
    endtask

    task automatic set_resp(input logic r, input logic l, input logic [31:0] d);
        oresp.ready = r;
        oresp.last  = l;
        oresp.data  = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn   = 1'b0;
        ireqs[0] = '0;
        ireqs[1] = '0;
        oresp    = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        ireqs[0] = '0;
        ireqs[1] = '0;
        oresp    = '0;
        @(negedge clk);
        set_resp(1'b1, 1'b1, 32'h1234_5678);
        #1;
        checks++;
        if (oreq !== '0)
            $display("[TB] FAIL reset_oreq: got %h expected 0", oreq);
        else passes++;
        checks++;
        if (iresps[0] !== '0 || iresps[1] !== '0)
            $display("[TB] FAIL reset_iresps: got %h/%h expected 0/0", iresps[0], iresps[1]);
        else passes++;
        oresp = '0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'd0, 4'h0);
        #1;
        checks++;
        if (oreq.valid !== 1'b0)
            $display("[TB] FAIL single_latency: got valid=%b expected 0", oreq.valid);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (oreq.valid !== 1'b1 || oreq.addr !== 32'hBFC0_0000 || oreq.is_write !== 1'b0)
            $display("[TB] FAIL single_grant: got valid=%b addr=%h expected 1/bfc00000",
                     oreq.valid, oreq.addr);
        else passes++;
        set_resp(1'b1, 1'b1, 32'h3C08_0001);
        #1;
        checks++;
        if (iresps[0].ready !== 1'b1 || iresps[0].last !== 1'b1 || iresps[0].data !== 32'h3C08_0001)
            $display("[TB] FAIL single_resp0: got %h expected ready/last with 3c080001", iresps[0]);
        else passes++;
        checks++;
        if (iresps[1] !== '0)
            $display("[TB] FAIL single_resp1: got %h expected 0", iresps[1]);
        else passes++;
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        oresp = '0;
        #1;
        checks++;
        if (oreq.valid !== 1'b0 || iresps[0] !== '0)
            $display("[TB] FAIL single_end: got valid=%b resp0=%h expected 0/0", oreq.valid, iresps[0]);
        else passes++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'd0, 4'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'd0, 4'h0);
        @(negedge clk);
        #1;
        checks++;
        if (oreq.valid !== 1'b1 || oreq.addr !== 32'h0000_1000)
            $display("[TB] FAIL simul_first: got valid=%b addr=%h expected 1/00001000", oreq.valid, oreq.addr);
        else passes++;
        set_resp(1'b1, 1'b1, 32'hAAAA_0000);
        #1;
        checks++;
        if (iresps[0].data !== 32'hAAAA_0000 || iresps[1] !== '0)
            $display("[TB] FAIL simul_route0: got %h/%h expected aaaa0000 on 0 only", iresps[0], iresps[1]);
        else passes++;
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        oresp = '0;
        #1;
        checks++;
        if (oreq.valid !== 1'b0)
            $display("[TB] FAIL simul_idle_gap: got valid=%b expected 0", oreq.valid);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (oreq.valid !== 1'b1 || oreq.addr !== 32'h0000_2000)
            $display("[TB] FAIL simul_second: got valid=%b addr=%h expected 1/00002000", oreq.valid, oreq.addr);
        else passes++;
        set_resp(1'b1, 1'b1, 32'hBBBB_0001);
        #1;
        checks++;
        if (iresps[1].data !== 32'hBBBB_0001 || iresps[1].ready !== 1'b1 || iresps[0] !== '0)
            $display("[TB] FAIL simul_route1: got %h/%h expected bbbb0001 on 1 only", iresps[0], iresps[1]);
        else passes++;
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        oresp = '0;
    endtask

    task automatic test_burst_hold();
        @(negedge clk);
        set_req(1, 1'b1, 1'b1, 32'h8000_0040, 32'hCAFE_F00D, 4'd3, 4'hF);
        @(negedge clk);
        #1;
        checks++;
        if (oreq.valid !== 1'b1 || oreq.is_write !== 1'b1 || oreq.strobe !== 4'hF ||
            oreq.len !== 4'd3 || oreq.data !== 32'hCAFE_F00D)
            $display("[TB] FAIL burst_grant: got %h expected req1 write", oreq);
        else passes++;
        for (int b = 0; b < 4; b++) begin
            if (b == 1) set_req(0, 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'd0, 4'h0);
            set_resp(1'b1, (b == 3), 32'h100 + b);
            #1;
            checks++;
            if (oreq.addr !== 32'h8000_0040 || iresps[1].ready !== 1'b1 || iresps[0] !== '0)
                $display("[TB] FAIL burst_beat%0d: got addr=%h r1=%b r0=%h expected 80000040/1/0",
                         b, oreq.addr, iresps[1].ready, iresps[0]);
            else passes++;
            @(negedge clk);
        end
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        oresp = '0;
        #1;
        checks++;
        if (oreq.valid !== 1'b0)
            $display("[TB] FAIL burst_idle: got valid=%b expected 0", oreq.valid);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (oreq.valid !== 1'b1 || oreq.addr !== 32'h0000_3000)
            $display("[TB] FAIL burst_next: got valid=%b addr=%h expected 1/00003000", oreq.valid, oreq.addr);
        else passes++;
        set_resp(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        oresp = '0;
    endtask

    task automatic test_round_robin();
        int exp_idx;
        int waited;
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_A000, 32'h0, 4'd0, 4'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_B000, 32'h0, 4'd0, 4'h0);
        for (int t = 0; t < 6; t++) begin
            exp_idx = t % 2;
            waited  = 0;
            #1;
            while (oreq.valid !== 1'b1 && waited < 4) begin
                @(negedge clk);
                #1;
                waited++;
            end
            checks++;
            if (oreq.valid !== 1'b1)
                $display("[TB] FAIL rr_timeout%0d: got valid=%b expected 1", t, oreq.valid);
            else if (oreq.addr !== (exp_idx == 0 ? 32'h0000_A000 : 32'h0000_B000))
                $display("[TB] FAIL rr_order%0d: got addr=%h expected grant to %0d", t, oreq.addr, exp_idx);
            else passes++;
            set_resp(1'b1, 1'b1, 32'h5000 + t);
            #1;
            checks++;
            if (iresps[exp_idx].ready !== 1'b1 || iresps[1 - exp_idx] !== '0)
                $display("[TB] FAIL rr_route%0d: got %h/%h expected response on %0d", t,
                         iresps[0], iresps[1], exp_idx);
            else passes++;
            @(negedge clk);
            oresp = '0;
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h0000_C000, 32'h0, 4'd3, 4'h0);
        @(negedge clk);
        set_resp(1'b1, 1'b0, 32'h1);
        @(negedge clk);
        set_resp(1'b1, 1'b0, 32'h2);
        #1;
        checks++;
        if (iresps[0].ready !== 1'b1 || oreq.valid !== 1'b1)
            $display("[TB] FAIL rstmid_beat2: got ready=%b valid=%b expected 1/1", iresps[0].ready, oreq.valid);
        else passes++;
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if (oreq.valid !== 1'b0 || iresps[0].ready !== 1'b0 || iresps[1].ready !== 1'b0)
            $display("[TB] FAIL rstmid_async: got valid=%b r0=%b r1=%b expected 0/0/0",
                     oreq.valid, iresps[0].ready, iresps[1].ready);
        else passes++;
        oresp = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (oreq.valid !== 1'b1 || oreq.addr !== 32'h0000_C000)
            $display("[TB] FAIL rstmid_regrant: got valid=%b addr=%h expected 1/0000c000", oreq.valid, oreq.addr);
        else passes++;
        @(negedge clk);
        set_resp(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        oresp = '0;
        @(negedge clk);
    endtask

    task automatic test_spurious_ready();
        @(negedge clk);
        set_resp(1'b1, 1'b1, 32'hDEAD_BEEF);
        #1;
        checks++;
        if (iresps[0] !== '0 || iresps[1] !== '0 || oreq.valid !== 1'b0)
            $display("[TB] FAIL spur_route: got %h/%h valid=%b expected 0/0/0", iresps[0], iresps[1], oreq.valid);
        else passes++;
        @(negedge clk);
        #1;
        checks++;
        if (iresps[0] !== '0 || iresps[1] !== '0 || oreq.valid !== 1'b0)
            $display("[TB] FAIL spur_hold: got %h/%h valid=%b expected 0/0/0", iresps[0], iresps[1], oreq.valid);
        else passes++;
        oresp = '0;
        set_req(1, 1'b1, 1'b0, 32'h0000_D000, 32'h0, 4'd0, 4'h0);
        @(negedge clk);
        #1;
        checks++;
        if (oreq.valid !== 1'b1 || oreq.addr !== 32'h0000_D000)
            $display("[TB] FAIL spur_after: got valid=%b addr=%h expected 1/0000d000", oreq.valid, oreq.addr);
        else passes++;
        set_resp(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 4'h0);
        oresp = '0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_burst_hold();
        test_round_robin();
        test_reset_mid_burst();
        test_spurious_ready();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
